cell_r_stream: RTL and testbench

//  Parametrised result-register array (DATA_DEPTH words x DATA_WIDTH bits) for the AP CAM datapath.

---
 rtl/cell_r_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_cell_r_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cell_r_stream.sv
// cell_r_stream
// Result-register array (DATA_DEPTH rows x DATA_WIDTH columns) for the AP CAM
// datapath. It supports row/column writes, bulk copy from A or B, clear, and
// tagged/masked write-back of A with pass-controlled inversion. A handshaked
// burst engine streams consecutive rows or columns, wrapping at the array edge.
//
// Ports
//   clk, rst_In            clock, async active-low reset
//   op, wr_addr            array op (1 ROW_WR, 2 COL_WR, 3 COPY_B, 5 COPY_A, 6 CLR)
//   wr_row, wr_col         row / column write data
//   q_a, q_b, q_s          source arrays (cell[i][j] at bit i*W+j), per-row signs
//   tag, mask              write-back row tags / column mask
//   wb_en, abs_opt, pass   write-back control
//   rd_start, rd_dir,
//   rd_base, rd_len        burst request (dir 0 rows / 1 columns, len = beats-1)
//   out_valid, out_ready,
//   out_data, out_idx,
//   out_last               beat stream
//   rd_busy, rd_err        burst in progress / rejected start pulse
//   q                      array state
//
// state    | meaning
// S_IDLE   | no burst; accepts rd_start
// S_STREAM | burst active; loads and presents beats
module cell_r_stream #(
    parameter  int DATA_WIDTH = 4,
    parameter  int DATA_DEPTH = 4,
    parameter  int ADDR_WIDTH = 8,
    localparam int OUT_WIDTH  = (DATA_WIDTH > DATA_DEPTH) ? DATA_WIDTH : DATA_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_In,
    input  logic [2:0]                       op,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_row,
    input  logic [DATA_DEPTH-1:0]            wr_col,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_a,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] q_b,
    input  logic [DATA_DEPTH-1:0]            q_s,
    input  logic [DATA_DEPTH-1:0]            tag,
    input  logic [DATA_WIDTH-1:0]            mask,
    input  logic                             wb_en,
    input  logic                             abs_opt,
    input  logic [1:0]                       pass,
    input  logic                             rd_start,
    input  logic                             rd_dir,
    input  logic [ADDR_WIDTH-1:0]            rd_base,
    input  logic [ADDR_WIDTH-1:0]            rd_len,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic [ADDR_WIDTH-1:0]            out_idx,
    output logic                             out_last,
    output logic                             rd_busy,
    output logic                             rd_err,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] q
);

    localparam logic [2:0] OP_ROW_WR = 3'd1;
    localparam logic [2:0] OP_COL_WR = 3'd2;
    localparam logic [2:0] OP_COPY_B = 3'd3;
    localparam logic [2:0] OP_COPY_A = 3'd5;
    localparam logic [2:0] OP_CLR    = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] ROW_EXT = ADDR_WIDTH'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] COL_EXT = ADDR_WIDTH'(DATA_WIDTH);

    typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;

    state_t                            r_state, w_state_next;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]  r_q, w_q_next;
    logic                              r_dir;
    logic [ADDR_WIDTH-1:0]             r_ptr, r_rem;
    logic                              r_valid, r_last, r_err;
    logic [OUT_WIDTH-1:0]              r_data, w_beat;
    logic [ADDR_WIDTH-1:0]             r_idx;
    logic [ADDR_WIDTH-1:0]             w_start_ext, w_cur_ext;
    logic                              w_start, w_err, w_load, w_done;
    logic                              w_hit, w_val, w_inv;

    // Array next-state: an op write on a cell beats write-back on that cell.
    always_comb begin
        w_q_next = r_q;
        w_hit    = 1'b0;
        w_val    = 1'b0;
        w_inv    = 1'b0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            for (int j = 0; j < DATA_WIDTH; j++) begin
                w_hit = 1'b0;
                w_val = 1'b0;
                unique case (op)
                    OP_ROW_WR: begin
                        w_hit = (wr_addr == ADDR_WIDTH'(i)) && (wr_addr < ROW_EXT);
                        w_val = wr_row[j];
                    end
                    OP_COL_WR: begin
                        w_hit = (wr_addr == ADDR_WIDTH'(j)) && (wr_addr < COL_EXT);
                        w_val = wr_col[i];
                    end
                    OP_COPY_B: begin
                        w_hit = 1'b1;
                        w_val = q_b[i*DATA_WIDTH+j];
                    end
                    OP_COPY_A: begin
                        w_hit = 1'b1;
                        w_val = q_a[i*DATA_WIDTH+j];
                    end
                    OP_CLR: begin
                        w_hit = 1'b1;
                        w_val = 1'b0;
                    end
                    default: ;
                endcase
                // abs passes only invert negative rows; plain passes 1/2 invert all
                w_inv = abs_opt ? (q_s[i] && pass[1]) : (pass == 2'd1 || pass == 2'd2);
                if (w_hit)
                    w_q_next[i*DATA_WIDTH+j] = w_val;
                else if (wb_en && tag[i] && mask[j])
                    w_q_next[i*DATA_WIDTH+j] = w_inv ? ~q_a[i*DATA_WIDTH+j] : q_a[i*DATA_WIDTH+j];
            end
        end
    end

    // Row or column selected by r_ptr, zero-extended to OUT_WIDTH.
    always_comb begin
        w_beat = '0;
        if (!r_dir) begin
            for (int i = 0; i < DATA_DEPTH; i++)
                if (r_ptr == ADDR_WIDTH'(i))
                    w_beat[DATA_WIDTH-1:0] = r_q[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            for (int i = 0; i < DATA_DEPTH; i++)
                for (int j = 0; j < DATA_WIDTH; j++)
                    if (r_ptr == ADDR_WIDTH'(j))
                        w_beat[i] = r_q[i*DATA_WIDTH+j];
        end
    end

    assign w_start_ext = rd_dir ? COL_EXT : ROW_EXT;
    assign w_cur_ext   = r_dir  ? COL_EXT : ROW_EXT;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_err        = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rd_start) begin
                    if (rd_base < w_start_ext) begin
                        w_start      = 1'b1;
                        w_state_next = S_STREAM;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                // first beat fills the empty output stage; later beats load on transfer
                if (!r_valid) begin
                    w_load = 1'b1;
                end else if (out_ready) begin
                    if (r_last) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_In) begin
        if (!rst_In) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_dir   <= 1'b0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_err   <= w_err;
            if (w_start) begin
                r_dir <= rd_dir;
                r_ptr <= rd_base;
                r_rem <= rd_len;
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_beat;
                r_idx   <= r_ptr;
                r_last  <= (r_rem == '0);
                r_rem   <= r_rem - ADDR_WIDTH'(1);
                r_ptr   <= (r_ptr == w_cur_ext - ADDR_WIDTH'(1)) ? '0 : r_ptr + ADDR_WIDTH'(1);
            end
            if (w_done) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign rd_busy   = (r_state == S_STREAM);
    assign rd_err    = r_err;

endmodule

// File: tb/tb_cell_r_stream.sv
module tb_cell_r_stream;

    logic        clk = 1'b0;
    logic        rst_In;
    logic [2:0]  op;
    logic [7:0]  wr_addr;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic [15:0] q_a, q_b;
    logic [3:0]  q_s, tag, mask;
    logic        wb_en, abs_opt;
    logic [1:0]  pass;
    logic        rd_start, rd_dir;
    logic [7:0]  rd_base, rd_len;
    logic        out_valid, out_ready, out_last, rd_busy, rd_err;
    logic [3:0]  out_data;
    logic [7:0]  out_idx;
    logic [15:0] q;

    int n_vec = 0;
    int n_err = 0;

    cell_r_stream #(.DATA_WIDTH(4), .DATA_DEPTH(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_In(rst_In), .op(op), .wr_addr(wr_addr), .wr_row(wr_row),
        .wr_col(wr_col), .q_a(q_a), .q_b(q_b), .q_s(q_s), .tag(tag), .mask(mask),
        .wb_en(wb_en), .abs_opt(abs_opt), .pass(pass), .rd_start(rd_start),
        .rd_dir(rd_dir), .rd_base(rd_base), .rd_len(rd_len), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .rd_busy(rd_busy), .rd_err(rd_err), .q(q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag_s, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag_s, input logic [3:0] d, input logic [7:0] idx,
                            input logic lst);
        chk({tag_s, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag_s, ".data"},  {28'd0, out_data},  {28'd0, d});
        chk({tag_s, ".idx"},   {24'd0, out_idx},   {24'd0, idx});
        chk({tag_s, ".last"},  {31'd0, out_last},  {31'd0, lst});
    endtask

    task automatic chk_idle(input string tag_s);
        chk({tag_s, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag_s, ".busy"},  {31'd0, rd_busy},   32'd0);
    endtask

    initial begin
        rst_In = 1'b0; op = 3'd0; wr_addr = '0; wr_row = '0; wr_col = '0;
        q_a = '0; q_b = '0; q_s = '0; tag = '0; mask = '0; wb_en = 1'b0;
        abs_opt = 1'b0; pass = '0; rd_start = 1'b0; rd_dir = 1'b0;
        rd_base = '0; rd_len = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.q", {16'd0, q}, 32'd0);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.data", {28'd0, out_data}, 32'd0);
        chk("rst.idx", {24'd0, out_idx}, 32'd0);
        chk("rst.last", {31'd0, out_last}, 32'd0);
        chk("rst.busy", {31'd0, rd_busy}, 32'd0);
        chk("rst.err", {31'd0, rd_err}, 32'd0);
        rst_In = 1'b1;
        tick();

        // row write then single-beat row burst
        op = 3'd1; wr_addr = 8'd1; wr_row = 4'hA;
        tick();
        op = 3'd0;
        chk("rowwr.q", {16'd0, q}, 32'h00A0);
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd1; rd_len = 8'd0; out_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("b1.busy", {31'd0, rd_busy}, 32'd1);
        chk("b1.valid0", {31'd0, out_valid}, 32'd0);
        tick();
        chk_beat("b1.beat0", 4'hA, 8'd1, 1'b1);
        tick();
        chk_idle("b1.end");

        // copy A then column burst wrapping 3 -> 0
        op = 3'd5; q_a = 16'h1234;
        tick();
        op = 3'd0;
        chk("copya.q", {16'd0, q}, 32'h1234);
        rd_start = 1'b1; rd_dir = 1'b1; rd_base = 8'd3; rd_len = 8'd1;
        tick();
        rd_start = 1'b0;
        tick();
        chk_beat("b2.beat0", 4'h0, 8'd3, 1'b0);
        tick();
        chk_beat("b2.beat1", 4'hA, 8'd0, 1'b1);
        tick();
        chk_idle("b2.end");

        // tagged write-back on row 0 only
        q_a = 16'h0005; wb_en = 1'b1; tag = 4'b0001; mask = 4'hF; pass = 2'd1; abs_opt = 1'b0;
        tick();
        chk("wb.pass1", {16'd0, q}, 32'h123A);
        pass = 2'd0;
        tick();
        chk("wb.pass0", {16'd0, q}, 32'h1235);
        abs_opt = 1'b1; pass = 2'd2; q_s = 4'b0001;
        tick();
        chk("wb.abs_neg", {16'd0, q}, 32'h123A);
        q_s = 4'b0000;
        tick();
        chk("wb.abs_pos", {16'd0, q}, 32'h1235);
        abs_opt = 1'b0; pass = 2'd1; mask = 4'b0011;
        tick();
        chk("wb.mask", {16'd0, q}, 32'h1236);
        mask = 4'hF; op = 3'd1; wr_addr = 8'd0; wr_row = 4'hF;
        tick();
        op = 3'd0; wb_en = 1'b0;
        chk("wb.op_prio", {16'd0, q}, 32'h123F);
        op = 3'd1; wr_addr = 8'd4; wr_row = 4'h0;
        tick();
        op = 3'd0;
        chk("rowwr.oob", {16'd0, q}, 32'h123F);

        // 4-beat burst with 3-cycle stall on beat 1 while the array is cleared
        op = 3'd3; q_b = 16'hDCBA;
        tick();
        op = 3'd0;
        chk("copyb.q", {16'd0, q}, 32'hDCBA);
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd2; rd_len = 8'd3; out_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        chk_beat("b3.beat0", 4'hC, 8'd2, 1'b0);
        tick();
        out_ready = 1'b0; op = 3'd6;
        tick();
        op = 3'd0;
        chk("clr.q", {16'd0, q}, 32'd0);
        chk_beat("b3.stall1", 4'hD, 8'd3, 1'b0);
        tick();
        chk_beat("b3.stall2", 4'hD, 8'd3, 1'b0);
        tick();
        chk_beat("b3.stall3", 4'hD, 8'd3, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_beat("b3.beat2", 4'h0, 8'd0, 1'b0);
        tick();
        chk_beat("b3.beat3", 4'h0, 8'd1, 1'b1);
        tick();
        chk_idle("b3.end");

        // out-of-range base rejected
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd4; rd_len = 8'd0;
        tick();
        rd_start = 1'b0;
        chk("err.pulse", {31'd0, rd_err}, 32'd1);
        chk("err.busy", {31'd0, rd_busy}, 32'd0);
        tick();
        chk("err.clear", {31'd0, rd_err}, 32'd0);

        // len beyond extent wraps; rd_start while busy ignored
        op = 3'd3; q_b = 16'h8421;
        tick();
        op = 3'd0;
        rd_start = 1'b1; rd_dir = 1'b1; rd_base = 8'd2; rd_len = 8'd4;
        tick();
        rd_start = 1'b0;
        tick();
        chk_beat("b4.beat0", 4'h4, 8'd2, 1'b0);
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd4; rd_len = 8'd0;
        tick();
        rd_start = 1'b0;
        chk_beat("b4.beat1", 4'h8, 8'd3, 1'b0);
        chk("b4.noerr", {31'd0, rd_err}, 32'd0);
        chk("b4.busy", {31'd0, rd_busy}, 32'd1);
        tick();
        chk_beat("b4.beat2", 4'h1, 8'd0, 1'b0);
        tick();
        chk_beat("b4.beat3", 4'h2, 8'd1, 1'b0);
        tick();
        chk_beat("b4.beat4", 4'h4, 8'd2, 1'b1);
        tick();
        chk_idle("b4.end");

        // asynchronous reset mid-burst, then restart
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd0; rd_len = 8'd3; out_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        tick();
        chk_beat("b5.beat0", 4'h1, 8'd0, 1'b0);
        #2 rst_In = 1'b0;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.busy", {31'd0, rd_busy}, 32'd0);
        chk("arst.data", {28'd0, out_data}, 32'd0);
        chk("arst.last", {31'd0, out_last}, 32'd0);
        chk("arst.q", {16'd0, q}, 32'd0);
        #2 rst_In = 1'b1;
        tick();
        chk_idle("arst.after");
        op = 3'd1; wr_addr = 8'd2; wr_row = 4'h7;
        tick();
        op = 3'd0;
        rd_start = 1'b1; rd_dir = 1'b0; rd_base = 8'd2; rd_len = 8'd0; out_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        chk_beat("b6.beat0", 4'h7, 8'd2, 1'b1);
        tick();
        chk_idle("b6.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
